// File: rtl/rectifier_pkg.sv
// Shared rectifier-board definitions: AD7822 controller state encodings and timing defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rectifier_pkg;

    // Controller states, 3-bit with IDLE at zero so a cleared register reads as idle.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CONVST   = 3'd1,
        ST_WAIT_EOC = 3'd2,
        ST_READ     = 3'd3,
        ST_QUIET    = 3'd4
    } adc_state_e;

    // AD7822 timing defaults at 50 MHz.
    localparam int unsigned AD7822_SAMPLE_PERIOD_CYC = 100; // 500 kS/s free-run
    localparam int unsigned AD7822_CONVST_LOW_CYC    = 2;   // >= 20 ns pulse
    localparam int unsigned AD7822_CONV_TIMEOUT_CYC  = 64;  // t_conv is ~21 clk
    localparam int unsigned AD7822_RD_LOW_CYC        = 3;
    localparam int unsigned AD7822_QUIET_CYC         = 10;

    function automatic int unsigned rect_max4(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level.
// Latency: 2 clocks from input change to output change.
// Backpressure: none, the level is sampled every clock.
//
// Ports: i_clock (clock), i_reset_n (sync reset, active low), i_d (async input),
//        o_q (synchronized output, RESET_VAL while in reset).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/adc_ad7822_ctrl.sv
// Bus master for one AD7822 8-bit ADC: CONVST pulse, wait for EOC, CS/RD read, latch DB.
// Latency: start -> CONVST_n low 1 clk; EOC_n fall -> RD_n low ~3 clk; o_valid 1 clk after last RD_n low.
// Backpressure: none; a period tick while busy is dropped and flagged on o_overrun, i_trigger while busy is ignored.
//
// Ports: i_clock, i_reset_n (sync, active low), i_enable (free-run), i_trigger (one-shot, IDLE only),
//        o_CONVST_n / o_CS_n / o_RD_n (ADC strobes, active low, registered), i_EOC_n (async), i_DB[7:0],
//        o_data[7:0] (last good sample), o_valid / o_timeout / o_overrun (1-clk pulses), o_busy (not IDLE).
module adc_ad7822_ctrl
    import rectifier_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD_CYC = AD7822_SAMPLE_PERIOD_CYC,
    parameter int unsigned CONVST_LOW_CYC    = AD7822_CONVST_LOW_CYC,
    parameter int unsigned CONV_TIMEOUT_CYC  = AD7822_CONV_TIMEOUT_CYC,
    parameter int unsigned RD_LOW_CYC        = AD7822_RD_LOW_CYC,
    parameter int unsigned QUIET_CYC         = AD7822_QUIET_CYC
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_enable,
    input  logic       i_trigger,
    output logic       o_CONVST_n,
    output logic       o_CS_n,
    output logic       o_RD_n,
    input  logic       i_EOC_n,
    input  logic [7:0] i_DB,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_timeout,
    output logic       o_overrun
);

    localparam int unsigned CNT_MAX = rect_max4(CONVST_LOW_CYC, CONV_TIMEOUT_CYC, RD_LOW_CYC, QUIET_CYC);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int unsigned TMR_W   = $clog2(SAMPLE_PERIOD_CYC) + 1;

    localparam logic [CNT_W-1:0] CNT_CONVST  = CNT_W'(CONVST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(CONV_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_RD      = CNT_W'(RD_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_QUIET   = CNT_W'(QUIET_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(SAMPLE_PERIOD_CYC - 1);

    adc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;
    logic             convst_n_q, convst_n_d;
    logic             rd_cs_n_q, rd_cs_n_d;   // CS_n and RD_n always move together

    logic tick;
    logic start;
    logic eoc_n_sync;
    logic read_done;
    logic timeout_hit;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_eoc_sync (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_d       (i_EOC_n),
        .o_q       (eoc_n_sync)
    );

    // Free-run period timer, parked at zero while disabled.
    always_comb begin
        tick    = i_enable && (timer_q == TMR_LAST);
        timer_d = timer_q + TMR_W'(1);
        if (!i_enable || tick) begin
            timer_d = '0;
        end
        // Tick and trigger together still give a single start.
        start = (tick || i_trigger) && (state_q == ST_IDLE);
    end

    // State register and all output/data flops.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            timer_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
            convst_n_q <= 1'b1;
            rd_cs_n_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
            convst_n_q <= convst_n_d;
            rd_cs_n_q  <= rd_cs_n_d;
        end
    end

    // Next state and shared down-counter.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        read_done   = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CONVST;
                    cnt_d   = CNT_CONVST;
                end
            end
            ST_CONVST: begin
                if (cnt_q == '0) begin
                    state_d = ST_WAIT_EOC;
                    cnt_d   = CNT_TIMEOUT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WAIT_EOC: begin
                // EOC is checked first so it wins over an expiring timeout.
                if (!eoc_n_sync) begin
                    state_d = ST_READ;
                    cnt_d   = CNT_RD;
                end else if (cnt_q == '0) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_QUIET;
                    cnt_d       = CNT_QUIET;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_READ: begin
                if (cnt_q == '0) begin
                    read_done = 1'b1;
                    state_d   = ST_QUIET;
                    cnt_d     = CNT_QUIET;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_QUIET: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so the ADC strobes are glitch-free
    // yet still change on the same edge as the state.
    always_comb begin
        convst_n_d = (state_d != ST_CONVST);
        rd_cs_n_d  = (state_d != ST_READ);
        busy_d     = (state_d != ST_IDLE);
        valid_d    = read_done;
        timeout_d  = timeout_hit;
        overrun_d  = tick && (state_q != ST_IDLE);
        // DB is taken on the edge that ends the last RD_n-low cycle.
        data_d     = read_done ? i_DB : data_q;
    end

    assign o_CONVST_n = convst_n_q;
    assign o_CS_n     = rd_cs_n_q;
    assign o_RD_n     = rd_cs_n_q;
    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_busy     = busy_q;
    assign o_timeout  = timeout_q;
    assign o_overrun  = overrun_q;

endmodule
